cache_axi_arbiter: RTL and testbench

- Shares the single AXI master port between all cache-side memory requesters.
- Read requesters: ICache refill / uncached instruction fetch, DCache line refill, uncached data read.
- Write requesters: DCache line writeback, uncached data write.
- Independent read and write FSMs with fixed priority, beat counting, line assembly/serialisation, and a read-after-write address hazard check. Sits between the cache top level and the AXI bridge.

---
 rtl/cache_axi_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI master port between the cache read requesters (inst, dline, dunc_r)
// and write requesters (dwb, dunc_w) using independent read and write FSMs.
module cache_axi_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     inst_req_i,
    input  logic [ADDR_W-1:0]        inst_addr_i,
    input  logic                     inst_uncached_i,
    output logic                     inst_rvalid_o,
    output logic [32*LINE_WORDS-1:0] inst_rdata_o,

    input  logic                     dline_req_i,
    input  logic [ADDR_W-1:0]        dline_addr_i,
    output logic                     dline_rvalid_o,
    output logic [32*LINE_WORDS-1:0] dline_rdata_o,

    input  logic                     dunc_rreq_i,
    input  logic [ADDR_W-1:0]        dunc_raddr_i,
    output logic                     dunc_rvalid_o,
    output logic [31:0]              dunc_rdata_o,

    input  logic                     dwb_req_i,
    input  logic [ADDR_W-1:0]        dwb_addr_i,
    input  logic [32*LINE_WORDS-1:0] dwb_wdata_i,
    output logic                     dwb_bvalid_o,

    input  logic                     dunc_wreq_i,
    input  logic [ADDR_W-1:0]        dunc_waddr_i,
    input  logic [31:0]              dunc_wdata_i,
    input  logic [3:0]               dunc_wstrb_i,
    output logic                     dunc_bvalid_o,

    output logic                     axi_ren_o,
    output logic [ADDR_W-1:0]        axi_raddr_o,
    output logic [3:0]               axi_rlen_o,
    input  logic                     axi_arready_i,
    input  logic                     axi_rvalid_i,
    input  logic [31:0]              axi_rdata_i,
    output logic                     axi_rready_o,

    output logic                     axi_wen_o,
    output logic [ADDR_W-1:0]        axi_waddr_o,
    output logic [3:0]               axi_wlen_o,
    input  logic                     axi_awready_i,
    output logic                     axi_wvalid_o,
    output logic [31:0]              axi_wdata_o,
    output logic [3:0]               axi_wstrb_o,
    output logic                     axi_wlast_o,
    input  logic                     axi_wready_i,
    input  logic                     axi_bvalid_i
);

    localparam int IDX_W     = $clog2(LINE_WORDS);
    localparam int OFF_W     = $clog2(LINE_WORDS * 4);
    localparam int LINE_BITS = 32 * LINE_WORDS;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RESP} rstate_e;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B}    wstate_e;
    typedef enum logic [1:0] {RID_INST, RID_DLINE, RID_DUNC} rid_e;
    typedef enum logic       {WID_DWB, WID_DUNC}             wid_e;

    rstate_e              rState_q, rState_d;
    rid_e                 rId_q, rId_d;
    logic [ADDR_W-1:0]    rAddr_q, rAddr_d;
    logic [IDX_W-1:0]     rLast_q, rLast_d;
    logic [IDX_W-1:0]     rCnt_q, rCnt_d;
    logic [LINE_BITS-1:0] rBuf_q, rBuf_d;

    wstate_e              wState_q, wState_d;
    wid_e                 wId_q, wId_d;
    logic [ADDR_W-1:0]    wAddr_q, wAddr_d;
    logic [IDX_W-1:0]     wLast_q, wLast_d;
    logic [IDX_W-1:0]     wCnt_q, wCnt_d;
    logic [LINE_BITS-1:0] wBuf_q, wBuf_d;
    logic [3:0]           wStrb_q, wStrb_d;
    logic                 bDone_q, bDone_d;

    logic                 writeBusy;
    logic                 dlineHazard;
    logic                 duncHazard;
    logic [31:0]          wWord;

    // Data reads must not overtake a pending write to the same line.
    assign writeBusy   = (wState_q != W_IDLE);
    assign dlineHazard = writeBusy && (dline_addr_i[ADDR_W-1:OFF_W] == wAddr_q[ADDR_W-1:OFF_W]);
    assign duncHazard  = writeBusy && (dunc_raddr_i[ADDR_W-1:OFF_W] == wAddr_q[ADDR_W-1:OFF_W]);

    always_comb begin
        rState_d = rState_q;
        rId_d    = rId_q;
        rAddr_d  = rAddr_q;
        rLast_d  = rLast_q;
        rCnt_d   = rCnt_q;
        rBuf_d   = rBuf_q;
        unique case (rState_q)
            R_IDLE: begin
                rCnt_d = '0;
                if (dline_req_i && !dlineHazard) begin
                    rId_d    = RID_DLINE;
                    rAddr_d  = dline_addr_i & LINE_MASK;
                    rLast_d  = LAST_IDX;
                    rState_d = R_AR;
                end else if (dunc_rreq_i && !duncHazard) begin
                    rId_d    = RID_DUNC;
                    rAddr_d  = dunc_raddr_i;
                    rLast_d  = '0;
                    rState_d = R_AR;
                end else if (inst_req_i) begin
                    rId_d    = RID_INST;
                    rAddr_d  = inst_uncached_i ? inst_addr_i : (inst_addr_i & LINE_MASK);
                    rLast_d  = inst_uncached_i ? '0 : LAST_IDX;
                    rState_d = R_AR;
                end
            end
            R_AR: begin
                if (axi_arready_i) rState_d = R_DATA;
            end
            R_DATA: begin
                if (axi_rvalid_i) begin
                    for (int k = 0; k < LINE_WORDS; k++) begin
                        if (rCnt_q == IDX_W'(k)) rBuf_d[k*32 +: 32] = axi_rdata_i;
                    end
                    if (rCnt_q == rLast_q) rState_d = R_RESP;
                    else                   rCnt_d   = rCnt_q + 1'b1;
                end
            end
            R_RESP: rState_d = R_IDLE;
            default: rState_d = R_IDLE;
        endcase
    end

    // bDone_q blocks a re-grant during the completion pulse, while the requester still holds req.
    always_comb begin
        wState_d = wState_q;
        wId_d    = wId_q;
        wAddr_d  = wAddr_q;
        wLast_d  = wLast_q;
        wCnt_d   = wCnt_q;
        wBuf_d   = wBuf_q;
        wStrb_d  = wStrb_q;
        bDone_d  = 1'b0;
        unique case (wState_q)
            W_IDLE: begin
                wCnt_d = '0;
                if (!bDone_q) begin
                    if (dunc_wreq_i) begin
                        wId_d    = WID_DUNC;
                        wAddr_d  = dunc_waddr_i;
                        wLast_d  = '0;
                        wBuf_d   = {{(LINE_BITS-32){1'b0}}, dunc_wdata_i};
                        wStrb_d  = dunc_wstrb_i;
                        wState_d = W_AW;
                    end else if (dwb_req_i) begin
                        wId_d    = WID_DWB;
                        wAddr_d  = dwb_addr_i & LINE_MASK;
                        wLast_d  = LAST_IDX;
                        wBuf_d   = dwb_wdata_i;
                        wStrb_d  = 4'hF;
                        wState_d = W_AW;
                    end
                end
            end
            W_AW: begin
                if (axi_awready_i) wState_d = W_DATA;
            end
            W_DATA: begin
                if (axi_wready_i) begin
                    if (wCnt_q == wLast_q) wState_d = W_B;
                    else                   wCnt_d   = wCnt_q + 1'b1;
                end
            end
            W_B: begin
                if (axi_bvalid_i) begin
                    bDone_d  = 1'b1;
                    wState_d = W_IDLE;
                end
            end
            default: wState_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rState_q <= R_IDLE;
            rId_q    <= RID_INST;
            rAddr_q  <= '0;
            rLast_q  <= '0;
            rCnt_q   <= '0;
            rBuf_q   <= '0;
            wState_q <= W_IDLE;
            wId_q    <= WID_DWB;
            wAddr_q  <= '0;
            wLast_q  <= '0;
            wCnt_q   <= '0;
            wBuf_q   <= '0;
            wStrb_q  <= '0;
            bDone_q  <= 1'b0;
        end else begin
            rState_q <= rState_d;
            rId_q    <= rId_d;
            rAddr_q  <= rAddr_d;
            rLast_q  <= rLast_d;
            rCnt_q   <= rCnt_d;
            rBuf_q   <= rBuf_d;
            wState_q <= wState_d;
            wId_q    <= wId_d;
            wAddr_q  <= wAddr_d;
            wLast_q  <= wLast_d;
            wCnt_q   <= wCnt_d;
            wBuf_q   <= wBuf_d;
            wStrb_q  <= wStrb_d;
            bDone_q  <= bDone_d;
        end
    end

    always_comb begin
        wWord = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (wCnt_q == IDX_W'(k)) wWord = wBuf_q[k*32 +: 32];
        end
    end

    assign axi_ren_o      = (rState_q == R_AR);
    assign axi_raddr_o    = rAddr_q;
    assign axi_rlen_o     = 4'(rLast_q);
    assign axi_rready_o   = (rState_q == R_DATA);

    assign inst_rvalid_o  = (rState_q == R_RESP) && (rId_q == RID_INST);
    assign dline_rvalid_o = (rState_q == R_RESP) && (rId_q == RID_DLINE);
    assign dunc_rvalid_o  = (rState_q == R_RESP) && (rId_q == RID_DUNC);
    assign inst_rdata_o   = rBuf_q;
    assign dline_rdata_o  = rBuf_q;
    assign dunc_rdata_o   = rBuf_q[31:0];

    assign axi_wen_o      = (wState_q == W_AW);
    assign axi_waddr_o    = wAddr_q;
    assign axi_wlen_o     = 4'(wLast_q);
    assign axi_wvalid_o   = (wState_q == W_DATA);
    assign axi_wdata_o    = axi_wvalid_o ? wWord : 32'h0;
    assign axi_wstrb_o    = axi_wvalid_o ? wStrb_q : 4'h0;
    assign axi_wlast_o    = axi_wvalid_o && (wCnt_q == wLast_q);

    assign dwb_bvalid_o   = bDone_q && (wId_q == WID_DWB);
    assign dunc_bvalid_o  = bDone_q && (wId_q == WID_DUNC);

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: expected AXI requests and returned data are
// queued when a request is raised and checked when the DUT presents them.
module tb_cache_axi_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         inst_req_i = 1'b0;
    logic [31:0]  inst_addr_i = '0;
    logic         inst_uncached_i = 1'b0;
    logic         inst_rvalid_o;
    logic [255:0] inst_rdata_o;
    logic         dline_req_i = 1'b0;
    logic [31:0]  dline_addr_i = '0;
    logic         dline_rvalid_o;
    logic [255:0] dline_rdata_o;
    logic         dunc_rreq_i = 1'b0;
    logic [31:0]  dunc_raddr_i = '0;
    logic         dunc_rvalid_o;
    logic [31:0]  dunc_rdata_o;
    logic         dwb_req_i = 1'b0;
    logic [31:0]  dwb_addr_i = '0;
    logic [255:0] dwb_wdata_i = '0;
    logic         dwb_bvalid_o;
    logic         dunc_wreq_i = 1'b0;
    logic [31:0]  dunc_waddr_i = '0;
    logic [31:0]  dunc_wdata_i = '0;
    logic [3:0]   dunc_wstrb_i = '0;
    logic         dunc_bvalid_o;
    logic         axi_ren_o;
    logic [31:0]  axi_raddr_o;
    logic [3:0]   axi_rlen_o;
    logic         axi_arready_i = 1'b0;
    logic         axi_rvalid_i = 1'b0;
    logic [31:0]  axi_rdata_i = '0;
    logic         axi_rready_o;
    logic         axi_wen_o;
    logic [31:0]  axi_waddr_o;
    logic [3:0]   axi_wlen_o;
    logic         axi_awready_i = 1'b0;
    logic         axi_wvalid_o;
    logic [31:0]  axi_wdata_o;
    logic [3:0]   axi_wstrb_o;
    logic         axi_wlast_o;
    logic         axi_wready_i = 1'b0;
    logic         axi_bvalid_i = 1'b0;

    cache_axi_arbiter #(.LINE_WORDS(8), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_uncached_i(inst_uncached_i),
        .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
        .dline_req_i(dline_req_i), .dline_addr_i(dline_addr_i),
        .dline_rvalid_o(dline_rvalid_o), .dline_rdata_o(dline_rdata_o),
        .dunc_rreq_i(dunc_rreq_i), .dunc_raddr_i(dunc_raddr_i),
        .dunc_rvalid_o(dunc_rvalid_o), .dunc_rdata_o(dunc_rdata_o),
        .dwb_req_i(dwb_req_i), .dwb_addr_i(dwb_addr_i), .dwb_wdata_i(dwb_wdata_i),
        .dwb_bvalid_o(dwb_bvalid_o),
        .dunc_wreq_i(dunc_wreq_i), .dunc_waddr_i(dunc_waddr_i), .dunc_wdata_i(dunc_wdata_i),
        .dunc_wstrb_i(dunc_wstrb_i), .dunc_bvalid_o(dunc_bvalid_o),
        .axi_ren_o(axi_ren_o), .axi_raddr_o(axi_raddr_o), .axi_rlen_o(axi_rlen_o),
        .axi_arready_i(axi_arready_i), .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i),
        .axi_rready_o(axi_rready_o),
        .axi_wen_o(axi_wen_o), .axi_waddr_o(axi_waddr_o), .axi_wlen_o(axi_wlen_o),
        .axi_awready_i(axi_awready_i), .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o),
        .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o), .axi_wready_i(axi_wready_i),
        .axi_bvalid_i(axi_bvalid_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [255:0] val;
    } exp_t;

    exp_t sb[$];
    int   nCompared = 0;
    int   nMismatched = 0;
    int   nBeat;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input string tag, input logic [255:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic popCheck(input logic [255:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            nCompared++;
            nMismatched++;
            $error("[TB] FAIL sb_underflow: observed %0h expected nothing queued", obs);
        end else begin
            e = sb.pop_front();
            checkOutput(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic waitRen(input string tag);
        for (int i = 0; i < 40 && axi_ren_o !== 1'b1; i++) tick();
        checkOutput(tag, axi_ren_o, 1'b1);
    endtask

    task automatic waitWen(input string tag);
        for (int i = 0; i < 40 && axi_wen_o !== 1'b1; i++) tick();
        checkOutput(tag, axi_wen_o, 1'b1);
    endtask

    // Plays the AXI read slave: accepts the address one cycle after ren, then streams beats.
    task automatic applyStimulus(input int beats, input logic [31:0] first);
        waitRen("ren_seen");
        popCheck(axi_raddr_o);
        popCheck(axi_rlen_o);
        tick();
        checkOutput("ren_held", axi_ren_o, 1'b1);
        axi_arready_i = 1'b1;
        tick();
        axi_arready_i = 1'b0;
        checkOutput("rready", axi_rready_o, 1'b1);
        for (int k = 0; k < beats; k++) begin
            axi_rvalid_i = 1'b1;
            axi_rdata_i  = first + k;
            tick();
        end
        axi_rvalid_i = 1'b0;
        axi_rdata_i  = '0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        checkOutput("rst_ren", axi_ren_o, 1'b0);
        checkOutput("rst_wen", axi_wen_o, 1'b0);
        checkOutput("rst_rready", axi_rready_o, 1'b0);
        checkOutput("rst_wvalid", axi_wvalid_o, 1'b0);
        checkOutput("rst_raddr", axi_raddr_o, 32'h0);
        checkOutput("rst_rdata", dline_rdata_o, 256'h0);
        tick();
        rst = 1'b1;
        tick();

        // 1: cached DCache refill
        dline_req_i  = 1'b1;
        dline_addr_i = 32'h0000_1044;
        pushExp("t1_raddr", 32'h0000_1040);
        pushExp("t1_rlen", 4'd7);
        pushExp("t1_word0", 32'h11);
        pushExp("t1_word7", 32'h18);
        applyStimulus(8, 32'h11);
        checkOutput("t1_dline_rvalid", dline_rvalid_o, 1'b1);
        checkOutput("t1_inst_rvalid_quiet", inst_rvalid_o, 1'b0);
        popCheck(dline_rdata_o[31:0]);
        popCheck(dline_rdata_o[255:224]);
        dline_req_i = 1'b0;
        tick();
        checkOutput("t1_rvalid_one_cycle", dline_rvalid_o, 1'b0);

        // 2: uncached data read beats a simultaneous instruction refill
        inst_req_i      = 1'b1;
        inst_addr_i     = 32'h0000_0104;
        inst_uncached_i = 1'b0;
        dunc_rreq_i     = 1'b1;
        dunc_raddr_i    = 32'hBFD0_0010;
        pushExp("t2_dunc_raddr", 32'hBFD0_0010);
        pushExp("t2_dunc_rlen", 4'd0);
        pushExp("t2_dunc_rdata", 32'h0000_ABCD);
        applyStimulus(1, 32'h0000_ABCD);
        checkOutput("t2_dunc_rvalid", dunc_rvalid_o, 1'b1);
        checkOutput("t2_inst_not_yet", inst_rvalid_o, 1'b0);
        popCheck(dunc_rdata_o);
        dunc_rreq_i = 1'b0;
        pushExp("t2_inst_raddr", 32'h0000_0100);
        pushExp("t2_inst_rlen", 4'd7);
        pushExp("t2_inst_word0", 32'h300);
        pushExp("t2_inst_word3", 32'h303);
        tick();
        checkOutput("t2_idle_gap", axi_ren_o, 1'b0);
        tick();
        checkOutput("t2_inst_start", axi_ren_o, 1'b1);
        applyStimulus(8, 32'h300);
        checkOutput("t2_inst_rvalid", inst_rvalid_o, 1'b1);
        popCheck(inst_rdata_o[31:0]);
        popCheck(inst_rdata_o[127:96]);
        inst_req_i = 1'b0;
        tick();

        // 3: writeback with throttled wready, hazard-blocked dline, concurrent inst
        dwb_req_i  = 1'b1;
        dwb_addr_i = 32'h0000_2000;
        for (int k = 0; k < 8; k++) dwb_wdata_i[k*32 +: 32] = 32'hA0 + k;
        pushExp("t3_waddr", 32'h0000_2000);
        pushExp("t3_wlen", 4'd7);
        for (int k = 0; k < 8; k++) pushExp($sformatf("t3_wdata%0d", k), 32'hA0 + k);
        waitWen("t3_wen");
        popCheck(axi_waddr_o);
        popCheck(axi_wlen_o);
        axi_awready_i = 1'b1;
        tick();
        axi_awready_i = 1'b0;
        dline_req_i     = 1'b1;
        dline_addr_i    = 32'h0000_2010;
        inst_req_i      = 1'b1;
        inst_addr_i     = 32'h0000_3000;
        inst_uncached_i = 1'b0;
        nBeat = 0;
        for (int c = 0; c < 40 && nBeat < 8; c++) begin
            if (c % 2 == 0) begin
                checkOutput("t3_wvalid", axi_wvalid_o, 1'b1);
                checkOutput("t3_wstrb", axi_wstrb_o, 4'hF);
                popCheck(axi_wdata_o);
                checkOutput("t3_wlast", axi_wlast_o, (nBeat == 7));
                axi_wready_i = 1'b1;
                nBeat++;
            end else begin
                axi_wready_i = 1'b0;
            end
            if (c == 1) begin
                checkOutput("t3_inst_concurrent_ren", axi_ren_o, 1'b1);
                checkOutput("t3_inst_over_dline", axi_raddr_o, 32'h0000_3000);
            end
            tick();
        end
        axi_wready_i = 1'b0;
        checkOutput("t3_wvalid_done", axi_wvalid_o, 1'b0);
        axi_bvalid_i = 1'b1;
        checkOutput("t3_no_early_bvalid", dwb_bvalid_o, 1'b0);
        tick();
        axi_bvalid_i = 1'b0;
        checkOutput("t3_dwb_bvalid", dwb_bvalid_o, 1'b1);
        dwb_req_i = 1'b0;
        tick();
        checkOutput("t3_bvalid_one_cycle", dwb_bvalid_o, 1'b0);
        checkOutput("t3_no_regrant", axi_wen_o, 1'b0);
        pushExp("t3_inst_raddr", 32'h0000_3000);
        pushExp("t3_inst_rlen", 4'd7);
        pushExp("t3_inst_word0", 32'h500);
        applyStimulus(8, 32'h500);
        checkOutput("t3_inst_rvalid", inst_rvalid_o, 1'b1);
        popCheck(inst_rdata_o[31:0]);
        inst_req_i = 1'b0;
        pushExp("t3_dline_raddr", 32'h0000_2000);
        pushExp("t3_dline_rlen", 4'd7);
        pushExp("t3_dline_word7", 32'h607);
        applyStimulus(8, 32'h600);
        checkOutput("t3_dline_rvalid", dline_rvalid_o, 1'b1);
        popCheck(dline_rdata_o[255:224]);
        dline_req_i = 1'b0;
        tick();

        // 4: uncached partial-strobe write
        dunc_wreq_i  = 1'b1;
        dunc_waddr_i = 32'hBFAF_F000;
        dunc_wdata_i = 32'h55;
        dunc_wstrb_i = 4'b0011;
        pushExp("t4_waddr", 32'hBFAF_F000);
        pushExp("t4_wlen", 4'd0);
        pushExp("t4_wdata", 32'h55);
        waitWen("t4_wen");
        popCheck(axi_waddr_o);
        popCheck(axi_wlen_o);
        axi_awready_i = 1'b1;
        tick();
        axi_awready_i = 1'b0;
        checkOutput("t4_wvalid", axi_wvalid_o, 1'b1);
        popCheck(axi_wdata_o);
        checkOutput("t4_wstrb", axi_wstrb_o, 4'b0011);
        checkOutput("t4_wlast", axi_wlast_o, 1'b1);
        axi_wready_i = 1'b1;
        tick();
        axi_wready_i = 1'b0;
        checkOutput("t4_wvalid_done", axi_wvalid_o, 1'b0);
        axi_bvalid_i = 1'b1;
        tick();
        axi_bvalid_i = 1'b0;
        checkOutput("t4_dunc_bvalid", dunc_bvalid_o, 1'b1);
        checkOutput("t4_dwb_bvalid_quiet", dwb_bvalid_o, 1'b0);
        dunc_wreq_i = 1'b0;
        tick();
        checkOutput("t4_bvalid_one_cycle", dunc_bvalid_o, 1'b0);

        // 5: reset in the middle of a refill burst
        dline_req_i  = 1'b1;
        dline_addr_i = 32'h0000_5008;
        pushExp("t5_raddr", 32'h0000_5000);
        pushExp("t5_rlen", 4'd7);
        waitRen("t5_ren");
        popCheck(axi_raddr_o);
        popCheck(axi_rlen_o);
        tick();
        axi_arready_i = 1'b1;
        tick();
        axi_arready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            axi_rvalid_i = 1'b1;
            axi_rdata_i  = 32'h70 + k;
            tick();
        end
        axi_rvalid_i = 1'b0;
        dline_req_i  = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("t5_rready_cleared", axi_rready_o, 1'b0);
        checkOutput("t5_ren_cleared", axi_ren_o, 1'b0);
        checkOutput("t5_raddr_cleared", axi_raddr_o, 32'h0);
        checkOutput("t5_rlen_cleared", axi_rlen_o, 4'h0);
        checkOutput("t5_rdata_cleared", dline_rdata_o, 256'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t5_no_rvalid", dline_rvalid_o, 1'b0);
        end
        rst = 1'b1;
        tick();
        dunc_rreq_i  = 1'b1;
        dunc_raddr_i = 32'h1234_5678;
        pushExp("t5_fresh_raddr", 32'h1234_5678);
        pushExp("t5_fresh_rlen", 4'd0);
        pushExp("t5_fresh_rdata", 32'h77);
        applyStimulus(1, 32'h77);
        checkOutput("t5_fresh_rvalid", dunc_rvalid_o, 1'b1);
        popCheck(dunc_rdata_o);
        dunc_rreq_i = 1'b0;
        tick();

        checkOutput("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
